mc_stage_ctrl: RTL and testbench

Parametrised multicycle sequencer for the five-stage core (IF/ID/EX/MEM/WB). It is the next generation of the stage controller and adds:
- a run gate
- a stall input
- a ready-based memory handshake with a wait-state timeout and sticky error
- retire pulse and instruction counter
Sits between the decoder, which supplies the control word, and the datapath stage registers and data memory port.

---
 rtl/mc_ctrl_pkg.sv | 34 +++
 rtl/mc_stage_ctrl_if.sv | 12 +
 rtl/mc_wait_timer.sv | 32 +++
 rtl/mc_stage_ctrl.sv | 157 +++++++++++++++
 tb/tb_mc_stage_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and constants for the multicycle stage controller.
//   state_e      - sequencer state encoding (3-bit)
//   JUMP..CONT   - bit positions inside the decoded control word
//   STG_*        - bit positions inside the one-hot stage_en vector
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_ERR  = 3'd6
  } state_e;

  // Control word bit map (bits above CW_USED_W-1 are reserved).
  localparam int unsigned JUMP     = 6;
  localparam int unsigned IMM      = 5;
  localparam int unsigned STORE    = 4;
  localparam int unsigned MEM      = 3;
  localparam int unsigned WBSEL_HI = 2;
  localparam int unsigned WBSEL_LO = 1;
  localparam int unsigned CONT     = 0;
  localparam int unsigned CW_USED_W = 7;

  // stage_en bit map {WB,MEM,EX,ID,IF}
  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;

endpackage

// File: rtl/mc_stage_ctrl_if.sv
// mc_stage_ctrl_if: data memory request/ready handshake.
//   mem_req   - controller requests an access this cycle
//   mem_we    - 1 store, 0 load; valid with mem_req
//   mem_ready - memory completes the access this cycle
interface mc_stage_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input  mem_ready);
  modport slave  (input  mem_req, input  mem_we, output mem_ready);
endinterface

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts consecutive memory wait cycles.
//   clk, rst - clock and synchronous active-high reset
//   clear    - zero the count (takes priority over enable)
//   enable   - increment the count
//   expired  - count has reached WAIT_MAX
module mc_wait_timer #(
  parameter int unsigned WAIT_W   = 4,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == WAIT_W'(WAIT_MAX));

endmodule

// File: rtl/mc_stage_ctrl.sv
// mc_stage_ctrl: multicycle IF/ID/EX/MEM/WB sequencer.
//   clk, rst     - clock, synchronous active-high reset
//   run          - leave IDLE / continue after retire
//   stall        - hold IF/ID/EX/WB with stage enables suppressed
//   ctrl         - decoded control word, captured in ID
//   mem          - data memory handshake (master side)
//   stage_en     - one-hot stage enable {WB,MEM,EX,ID,IF}
//   jump_en      - IF takes jump target of the previous instruction
//   imm_en       - EX operand B is the immediate
//   expc_en      - EX produces a PC-relative result
//   wb_ctrl      - WB source select
//   retire       - registered one-cycle completion pulse
//   err          - sticky memory-timeout error
//   instret      - retired instruction count
module mc_stage_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_W   = 7,
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned WAIT_W   = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              stall,
  input  logic [CTRL_W-1:0] ctrl,
  mc_stage_ctrl_if.master   mem,
  output logic [4:0]        stage_en,
  output logic              jump_en,
  output logic              imm_en,
  output logic              expc_en,
  output logic [1:0]        wb_ctrl,
  output logic              retire,
  output logic              err,
  output logic [CNT_W-1:0]  instret
);

  state_e                 state_q, state_d;
  logic [CW_USED_W-1:0]   ctrl_q, ctrl_d;
  logic                   jump_q, jump_d;
  logic                   err_q, err_d;
  logic                   retire_q, retire_d;
  logic [CNT_W-1:0]       instret_q, instret_d;
  logic                   wait_en, wait_expired, done;

  mc_wait_timer #(
    .WAIT_W   (WAIT_W),
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!wait_en),
    .enable  (wait_en),
    .expired (wait_expired)
  );

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    jump_d      = jump_q;
    err_d       = err_q;
    instret_d   = instret_q;
    retire_d    = 1'b0;
    done        = 1'b0;
    wait_en     = 1'b0;
    stage_en    = '0;
    jump_en     = 1'b0;
    imm_en      = 1'b0;
    expc_en     = 1'b0;
    wb_ctrl     = '0;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;

    case (state_q)
      S_IDLE: if (run) state_d = S_IF;
      S_IF: begin
        jump_en = jump_q;
        if (!stall) begin
          stage_en[STG_IF] = 1'b1;
          state_d          = S_ID;
        end
      end
      S_ID: begin
        if (!stall) begin
          stage_en[STG_ID] = 1'b1;
          ctrl_d           = ctrl[CW_USED_W-1:0];
          state_d          = S_EX;
        end
      end
      S_EX: begin
        imm_en  = ctrl_q[IMM];
        expc_en = (ctrl_q[WBSEL_HI:WBSEL_LO] == 2'b01);
        if (!stall) begin
          stage_en[STG_EX] = 1'b1;
          if (!ctrl_q[CONT])    done    = 1'b1;
          else if (ctrl_q[MEM]) state_d = S_MEM;
          else                  state_d = S_WB;
        end
      end
      S_MEM: begin
        stage_en[STG_MEM] = 1'b1;
        mem.mem_req       = 1'b1;
        mem.mem_we        = ctrl_q[STORE];
        // Ready wins over timeout, so completion on the last allowed cycle is normal.
        if (mem.mem_ready) begin
          if (ctrl_q[STORE]) done    = 1'b1;
          else               state_d = S_WB;
        end else if (wait_expired) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          wait_en = 1'b1;
        end
      end
      S_WB: begin
        wb_ctrl = ctrl_q[WBSEL_HI:WBSEL_LO];
        if (!stall) begin
          stage_en[STG_WB] = 1'b1;
          done             = 1'b1;
        end
      end
      S_ERR:   ;
      default: state_d = S_IDLE;
    endcase

    if (done) begin
      retire_d  = 1'b1;
      instret_d = instret_q + 1'b1;
      jump_d    = ctrl_q[JUMP];
      state_d   = run ? S_IF : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      jump_q    <= 1'b0;
      err_q     <= 1'b0;
      retire_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      jump_q    <= jump_d;
      err_q     <= err_d;
      retire_q  <= retire_d;
      instret_q <= instret_d;
    end
  end

  assign retire  = retire_q;
  assign err     = err_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_mc_stage_ctrl.sv
module tb_mc_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic        stall;
  logic [6:0]  ctrl;
  logic [4:0]  stage_en;
  logic        jump_en, imm_en, expc_en, retire, err;
  logic [1:0]  wb_ctrl;
  logic [31:0] instret;

  mc_stage_ctrl_if mem_if ();

  mc_stage_ctrl #(
    .CTRL_W   (7),
    .WAIT_MAX (15),
    .WAIT_W   (4),
    .CNT_W    (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .stall    (stall),
    .ctrl     (ctrl),
    .mem      (mem_if),
    .stage_en (stage_en),
    .jump_en  (jump_en),
    .imm_en   (imm_en),
    .expc_en  (expc_en),
    .wb_ctrl  (wb_ctrl),
    .retire   (retire),
    .err      (err),
    .instret  (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_cyc   = 0;

  logic [13:0] sb[$];
  logic        pend;
  logic        jump_exp;
  int unsigned exp_instret;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // {stage_en, jump_en, imm_en, expc_en, mem_req, mem_we, wb_ctrl, retire, err}
  function automatic logic [13:0] ev(input logic [4:0] stg, input logic j, input logic i,
                                     input logic x, input logic rq, input logic we,
                                     input logic [1:0] wb, input logic rt, input logic er);
    return {stg, j, i, x, rq, we, wb, rt, er};
  endfunction

  // Scoreboard consumer: one expected vector per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [13:0] e;
      e = sb.pop_front();
      n_cyc++;
      chk($sformatf("cyc%0d", n_cyc),
          {18'd0, stage_en, jump_en, imm_en, expc_en, mem_if.mem_req, mem_if.mem_we,
           wb_ctrl, retire, err},
          {18'd0, e});
    end
  end

  task automatic exp_cyc(input logic [13:0] e, input logic st, input logic rdy);
    sb.push_back(e);
    stall            = st;
    mem_if.mem_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc(input logic r);
    run = r;
    exp_cyc(ev(5'b0, 0, 0, 0, 0, 0, 2'b00, pend, 0), 0, 0);
    pend = 1'b0;
  endtask

  task automatic front(input logic [6:0] c, input int unsigned s);
    logic im, xp;
    im   = c[5];
    xp   = (c[2:1] == 2'b01);
    ctrl = c;
    exp_cyc(ev(5'b00001, jump_exp, 0, 0, 0, 0, 2'b00, pend, 0), 0, 0);
    pend = 1'b0;
    exp_cyc(ev(5'b00010, 0, 0, 0, 0, 0, 2'b00, 0, 0), 0, 0);
    for (int unsigned k = 0; k < s; k++)
      exp_cyc(ev(5'b00000, 0, im, xp, 0, 0, 2'b00, 0, 0), 1, 0);
    exp_cyc(ev(5'b00100, 0, im, xp, 0, 0, 2'b00, 0, 0), 0, 0);
  endtask

  // Full instruction; called in its IF cycle, returns in its retire cycle.
  task automatic run_instr(input logic [6:0] c, input int unsigned w, input int unsigned s,
                           input logic run_next);
    run = run_next;
    front(c, s);
    if (c[0]) begin
      if (c[3]) begin
        // stall asserted while waiting must be ignored in MEM
        for (int unsigned k = 0; k < w; k++)
          exp_cyc(ev(5'b01000, 0, 0, 0, 1, c[4], 2'b00, 0, 0), 1, 0);
        exp_cyc(ev(5'b01000, 0, 0, 0, 1, c[4], 2'b00, 0, 0), 0, 1);
      end
      if (!(c[3] && c[4]))
        exp_cyc(ev(5'b10000, 0, 0, 0, 0, 0, c[2:1], 0, 0), 0, 0);
    end
    pend     = 1'b1;
    jump_exp = c[6];
    exp_instret++;
    chk("instret", instret, exp_instret);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; stall = 1'b0; ctrl = '0; mem_if.mem_ready = 1'b0;
    pend = 1'b0; jump_exp = 1'b0; exp_instret = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_instret", instret, 0);
    idle_cyc(0);
    idle_cyc(1);

    run_instr(7'b0000000, 0, 0, 1);   // ALU only
    run_instr(7'b0001001, 2, 0, 1);   // load, ready on 3rd MEM cycle
    run_instr(7'b1100011, 0, 0, 1);   // jump, imm, PC-relative, WB
    run_instr(7'b0000001, 0, 4, 0);   // jump_en from previous; EX stall; run drops
    idle_cyc(0);                      // retire seen in IDLE
    idle_cyc(0);
    idle_cyc(1);
    run_instr(7'b0011001, 3, 0, 1);   // store with waits, jump_en now 0
    run_instr(7'b0001001, 15, 0, 1);  // ready on the last allowed MEM cycle

    // Reset during a store's memory wait: abort, no retire.
    run = 1'b1;
    front(7'b0011001, 0);
    exp_cyc(ev(5'b01000, 0, 0, 0, 1, 1, 2'b00, 0, 0), 0, 0);
    exp_cyc(ev(5'b01000, 0, 0, 0, 1, 1, 2'b00, 0, 0), 0, 0);
    sb.push_back(ev(5'b01000, 0, 0, 0, 1, 1, 2'b00, 0, 0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pend = 1'b0; jump_exp = 1'b0; exp_instret = 0;
    idle_cyc(0);
    chk("abort_instret", instret, 0);

    // Memory never ready: timeout into sticky ERR.
    idle_cyc(1);
    front(7'b0011001, 0);
    for (int unsigned k = 0; k < 16; k++)
      exp_cyc(ev(5'b01000, 0, 0, 0, 1, 1, 2'b00, 0, 0), 0, 0);
    exp_cyc(ev(5'b0, 0, 0, 0, 0, 0, 2'b00, 0, 1), 0, 0);
    exp_cyc(ev(5'b0, 0, 0, 0, 0, 0, 2'b00, 0, 1), 1, 1);
    exp_cyc(ev(5'b0, 0, 0, 0, 0, 0, 2'b00, 0, 1), 0, 1);
    chk("err_instret", instret, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cyc(0);
    chk("err_cleared", {31'd0, err}, 0);

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
